// File: rtl/iec_sd_arbiter_if.sv
// rtl/iec_sd_arbiter_if.sv - signal bundle between iec_drive instances, the arbiter and the host SD port
// Purpose : groups the per-drive request lanes and the shared host SD request port
// Ports   :
//   drv_lba, drv_sz, drv_rd, drv_wr, drv_buff_din  - per-drive request side, drive i at slice i
//   drv_ack, drv_buff_wr                           - per-drive acknowledge / gated buffer write
//   sd_lba, sd_sz, sd_rd, sd_wr, sd_buff_din       - host request side
//   sd_ack, sd_buff_wr                             - host acknowledge / buffer write strobe
//   busy, grant                                    - arbiter status, grant valid while busy
//   modport slave  : arbiter view
//   modport master : environment view (drives and host)
interface iec_sd_arbiter_if #(
   parameter int NDRV = 2
);
   logic [NDRV*32-1:0] drv_lba;
   logic [NDRV*6-1:0]  drv_sz;
   logic [NDRV-1:0]    drv_rd;
   logic [NDRV-1:0]    drv_wr;
   logic [NDRV*8-1:0]  drv_buff_din;
   logic [NDRV-1:0]    drv_ack;
   logic [NDRV-1:0]    drv_buff_wr;

   logic [31:0]        sd_lba;
   logic [5:0]         sd_sz;
   logic               sd_rd;
   logic               sd_wr;
   logic               sd_ack;
   logic               sd_buff_wr;
   logic [7:0]         sd_buff_din;

   logic               busy;
   logic [1:0]         grant;

   modport slave (
      input  drv_lba, drv_sz, drv_rd, drv_wr, drv_buff_din, sd_ack, sd_buff_wr,
      output drv_ack, drv_buff_wr, sd_lba, sd_sz, sd_rd, sd_wr, sd_buff_din, busy, grant
   );

   modport master (
      output drv_lba, drv_sz, drv_rd, drv_wr, drv_buff_din, sd_ack, sd_buff_wr,
      input  drv_ack, drv_buff_wr, sd_lba, sd_sz, sd_rd, sd_wr, sd_buff_din, busy, grant
   );
endinterface

// File: rtl/iec_sd_arbiter.sv
// rtl/iec_sd_arbiter.sv - round-robin arbiter sharing one host SD port among NDRV iec_drive instances
// Purpose : grants the host SD port to one drive at a time, latches its request, gates the
//           host buffer write strobe and acknowledge back to the granted drive only
// Ports   :
//   clk_sys - sole clock, rising edge
//   reset   - synchronous active-high reset
//   bus     - iec_sd_arbiter_if.slave (per-drive lanes, host SD port, busy/grant status)
module iec_sd_arbiter #(
   parameter int NDRV = 2
) (
   input  logic            clk_sys,
   input  logic            reset,
   iec_sd_arbiter_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_REQ  = 4'b0010,
      S_XFER = 4'b0100,
      S_DONE = 4'b1000
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_last;
   logic [1:0]  r_grant;
   logic [31:0] r_lba;
   logic [5:0]  r_sz;
   logic        r_op_rd;
   logic        r_op_wr;

   logic        w_found;
   logic [1:0]  w_sel;
   logic        w_sel_rd;
   logic [31:0] w_sel_lba;
   logic [5:0]  w_sel_sz;
   logic        w_grant_now;

   // Round-robin search: candidate k is drive (last+1+k) mod NDRV, lowest k with a request wins.
   always_comb begin : rr_pick
      int t;
      t       = 0;
      w_found = 1'b0;
      w_sel   = 2'd0;
      for (int k = 0; k < NDRV; k++) begin
         t = int'(r_last) + 1 + k;
         if (t >= NDRV) t = t - NDRV;
         for (int i = 0; i < NDRV; i++) begin
            if (!w_found && (i == t) && (bus.drv_rd[i] || bus.drv_wr[i])) begin
               w_found = 1'b1;
               w_sel   = 2'(i);
            end
         end
      end
   end

   always_comb begin : sel_mux
      w_sel_rd  = 1'b0;
      w_sel_lba = '0;
      w_sel_sz  = '0;
      for (int i = 0; i < NDRV; i++) begin
         if (w_sel == 2'(i)) begin
            w_sel_rd  = bus.drv_rd[i];
            w_sel_lba = bus.drv_lba[i*32 +: 32];
            w_sel_sz  = bus.drv_sz[i*6 +: 6];
         end
      end
   end

   // Host ack must be low before a new grant, so a transfer cut short by reset drains first.
   assign w_grant_now = (r_state == S_IDLE) && w_found && !bus.sd_ack;

   always_ff @(posedge clk_sys) begin : state_reg
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin : next_state
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_grant_now) w_next = S_REQ;
         S_REQ:   if (bus.sd_ack)  w_next = S_XFER;
         S_XFER:  if (!bus.sd_ack) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Request is frozen at grant; a read wins over a simultaneous write from the same drive,
   // leaving the write level pending for a later round.
   always_ff @(posedge clk_sys) begin : grant_latch
      if (reset) begin
         r_last  <= 2'(NDRV-1);
         r_grant <= 2'd0;
         r_lba   <= '0;
         r_sz    <= '0;
         r_op_rd <= 1'b0;
         r_op_wr <= 1'b0;
      end else if (w_grant_now) begin
         r_last  <= w_sel;
         r_grant <= w_sel;
         r_lba   <= w_sel_lba;
         r_sz    <= w_sel_sz;
         r_op_rd <= w_sel_rd;
         r_op_wr <= !w_sel_rd;
      end
   end

   // drv_ack is decoded from the registered state, giving the one-cycle lag behind sd_ack.
   always_comb begin : outputs
      bus.busy        = (r_state != S_IDLE);
      bus.sd_rd       = (r_state == S_REQ) && r_op_rd;
      bus.sd_wr       = (r_state == S_REQ) && r_op_wr;
      bus.sd_lba      = r_lba;
      bus.sd_sz       = r_sz;
      bus.grant       = r_grant;
      bus.drv_ack     = '0;
      bus.drv_buff_wr = '0;
      bus.sd_buff_din = '0;
      for (int i = 0; i < NDRV; i++) begin
         if (r_grant == 2'(i)) begin
            bus.sd_buff_din = bus.drv_buff_din[i*8 +: 8];
            if (r_state == S_XFER) begin
               bus.drv_ack[i]     = 1'b1;
               bus.drv_buff_wr[i] = bus.sd_buff_wr;
            end
         end
      end
   end

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// tb/tb_iec_sd_arbiter.sv - randomized self-checking bench for iec_sd_arbiter against a transaction model
module tb_iec_sd_arbiter;
   localparam int NDRV = 2;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_sys = ~clk_sys;

   iec_sd_arbiter_if #(.NDRV(NDRV)) bus ();

   iec_sd_arbiter #(.NDRV(NDRV)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   // Model: what each drive is asking for, plus the round-robin pointer.
   bit          p_rd  [NDRV];
   bit          p_wr  [NDRV];
   logic [31:0] p_lba [NDRV];
   logic [5:0]  p_sz  [NDRV];
   logic [7:0]  p_din [NDRV];
   int          m_last;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic nxt();
      @(negedge clk_sys);
      #1;
   endtask

   function automatic logic [NDRV-1:0] oh(input int i);
      logic [NDRV-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int pick();
      for (int k = 1; k <= NDRV; k++) begin
         int d;
         d = (m_last + k) % NDRV;
         if (p_rd[d] || p_wr[d]) return d;
      end
      return -1;
   endfunction

   task automatic drive_drv();
      for (int i = 0; i < NDRV; i++) begin
         bus.drv_rd[i]               = p_rd[i];
         bus.drv_wr[i]               = p_wr[i];
         bus.drv_lba[i*32 +: 32]     = p_lba[i];
         bus.drv_sz[i*6 +: 6]        = p_sz[i];
         bus.drv_buff_din[i*8 +: 8]  = p_din[i];
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NDRV; i++) begin
         p_rd[i] = 1'b0;
         p_wr[i] = 1'b0;
      end
      drive_drv();
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      bus.sd_ack     = 1'b0;
      bus.sd_buff_wr = 1'b0;
      nxt();
      nxt();
      reset  = 1'b0;
      m_last = NDRV - 1;
   endtask

   // One host transaction: wait for the request, check it, hold in REQ, ack, move nb strobes,
   // release ack, and stop in the DONE cycle.
   task automatic xact(input int nb, input bit dense, input int hold, input bit drop,
                       input int exp_wait, output int g);
      int          eg;
      int          w;
      int          ecnt;
      int          cnt [NDRV];
      bit          erd;
      logic [31:0] elba;
      logic [5:0]  esz;
      eg = pick();
      g  = eg;
      if (eg < 0) begin
         chk("model_pending", 0, 1);
         return;
      end
      erd  = p_rd[eg];
      elba = p_lba[eg];
      esz  = p_sz[eg];
      w = 0;
      do begin
         nxt();
         w++;
      end while (!(bus.sd_rd || bus.sd_wr) && w < 8);
      chk("req_wait", w, exp_wait);
      chk("grant", bus.grant, eg);
      chk("sd_lba", bus.sd_lba, elba);
      chk("sd_sz", bus.sd_sz, esz);
      chk("sd_rd", bus.sd_rd, erd);
      chk("sd_wr", bus.sd_wr, !erd);
      chk("busy_req", bus.busy, 1);
      chk("din_req", bus.sd_buff_din, p_din[eg]);
      for (int h = 0; h < hold; h++) begin
         p_lba[eg] = $urandom;
         p_sz[eg]  = 6'($urandom);
         if (drop && h == 0) begin
            if (erd) p_rd[eg] = 1'b0;
            else     p_wr[eg] = 1'b0;
         end
         drive_drv();
         nxt();
         chk("hold_rd", bus.sd_rd, erd);
         chk("hold_wr", bus.sd_wr, !erd);
         chk("hold_lba", bus.sd_lba, elba);
         chk("hold_sz", bus.sd_sz, esz);
      end
      bus.sd_ack = 1'b1;
      nxt();
      chk("xfer_rd", bus.sd_rd, 0);
      chk("xfer_wr", bus.sd_wr, 0);
      chk("xfer_ack", bus.drv_ack, oh(eg));
      chk("xfer_busy", bus.busy, 1);
      if (erd) p_rd[eg] = 1'b0;
      else     p_wr[eg] = 1'b0;
      drive_drv();
      m_last = eg;
      ecnt = 0;
      for (int i = 0; i < NDRV; i++) cnt[i] = 0;
      for (int b = 0; b < nb; b++) begin
         bus.sd_buff_wr = dense ? 1'b1 : 1'($urandom_range(0, 1));
         if (bus.sd_buff_wr) ecnt++;
         #1;
         for (int i = 0; i < NDRV; i++) cnt[i] += int'(bus.drv_buff_wr[i]);
         chk("xfer_din", bus.sd_buff_din, p_din[eg]);
         nxt();
      end
      for (int i = 0; i < NDRV; i++) chk($sformatf("bwr_cnt%0d", i), cnt[i], (i == eg) ? ecnt : 0);
      bus.sd_buff_wr = 1'b0;
      bus.sd_ack     = 1'b0;
      nxt();
      bus.sd_buff_wr = 1'b1;
      #1;
      chk("done_busy", bus.busy, 1);
      chk("done_rd", bus.sd_rd | bus.sd_wr, 0);
      chk("done_ack", bus.drv_ack, 0);
      chk("done_bwr", bus.drv_buff_wr, 0);
      bus.sd_buff_wr = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int hold;
      bit drop;
      int seq [6];
      bus.sd_ack     = 1'b0;
      bus.sd_buff_wr = 1'b0;
      for (int i = 0; i < NDRV; i++) begin
         p_rd[i]  = 1'b0;
         p_wr[i]  = 1'b0;
         p_lba[i] = '0;
         p_sz[i]  = '0;
         p_din[i] = '0;
      end
      drive_drv();
      do_reset();

      chk("rst_busy", bus.busy, 0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_lba", bus.sd_lba, 0);
      chk("rst_sz", bus.sd_sz, 0);
      chk("rst_rdwr", {bus.sd_rd, bus.sd_wr}, 0);
      chk("rst_ack", bus.drv_ack, 0);

      // single read on drive 1, 256 dense strobes
      p_rd[1] = 1'b1; p_lba[1] = 32'h0000_0165; p_sz[1] = 6'd0; p_din[1] = 8'h3C;
      drive_drv();
      xact(256, 1'b1, 0, 1'b0, 1, g);

      // write on drive 0 with 0xA5
      p_wr[0] = 1'b1; p_lba[0] = 32'h0000_1000; p_sz[0] = 6'd3; p_din[0] = 8'hA5;
      drive_drv();
      xact(4, 1'b1, 1, 1'b0, 2, g);

      // contention right after reset: drive 0 then drive 1
      do_reset();
      p_rd[0] = 1'b1; p_rd[1] = 1'b1; p_lba[0] = 32'h10; p_lba[1] = 32'h20;
      drive_drv();
      xact(3, 1'b0, 0, 1'b0, 1, g);
      chk("contend_first", g, 0);
      xact(3, 1'b0, 0, 1'b0, 2, g);
      chk("contend_second", g, 1);

      // fairness with continuous requests
      seq = '{0, 1, 0, 1, 0, 1};
      do_reset();
      p_rd[0] = 1'b1; p_rd[1] = 1'b1;
      drive_drv();
      for (int t = 0; t < 6; t++) begin
         xact(2, 1'b1, 0, 1'b0, (t == 0) ? 1 : 2, g);
         chk($sformatf("fair%0d", t), g, seq[t]);
         if (g >= 0) p_rd[g] = 1'b1;
         drive_drv();
      end
      clear_reqs();
      nxt();
      nxt();

      // rd+wr on one drive, lba changed during REQ
      p_rd[0] = 1'b1; p_wr[0] = 1'b1; p_lba[0] = 32'hCAFE_0001;
      drive_drv();
      xact(2, 1'b1, 2, 1'b0, 1, g);
      chk("rdwr_first_drv", g, 0);
      chk("rdwr_wr_left", bus.drv_wr[0], 1);
      xact(2, 1'b1, 0, 1'b0, 2, g);
      chk("rdwr_second_drv", g, 0);

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < NDRV; i++) begin
            if (!p_rd[i] && !p_wr[i] && $urandom_range(0, 2) != 0) begin
               p_rd[i]  = 1'($urandom_range(0, 1));
               p_wr[i]  = 1'($urandom_range(0, 1));
               if (!p_rd[i] && !p_wr[i]) p_rd[i] = 1'b1;
               p_lba[i] = $urandom;
               p_sz[i]  = 6'($urandom);
            end
            p_din[i] = 8'($urandom);
         end
         if (pick() < 0) begin
            g = $urandom_range(0, NDRV - 1);
            p_wr[g] = 1'b1;
         end
         drive_drv();
         hold = $urandom_range(0, 2);
         drop = (hold > 0) && ($urandom_range(0, 3) == 0);
         xact($urandom_range(1, 8), 1'b0, hold, drop, 2, g);
      end

      // reset during XFER with host ack still high
      clear_reqs();
      p_rd[1] = 1'b1; p_lba[1] = 32'h0000_0777;
      drive_drv();
      nxt();
      nxt();
      nxt();
      chk("rx_req", bus.sd_rd, 1);
      bus.sd_ack = 1'b1;
      nxt();
      chk("rx_xfer", bus.drv_ack[1], 1);
      reset = 1'b1;
      nxt();
      reset  = 1'b0;
      m_last = NDRV - 1;
      chk("rx_busy", bus.busy, 0);
      chk("rx_ack", bus.drv_ack, 0);
      chk("rx_grant", bus.grant, 0);
      chk("rx_lba", bus.sd_lba, 0);
      chk("rx_sz", bus.sd_sz, 0);
      for (int c = 0; c < 5; c++) begin
         nxt();
         chk($sformatf("rx_norq%0d", c), {bus.sd_rd, bus.sd_wr, bus.busy}, 0);
      end
      bus.sd_ack = 1'b0;
      xact(2, 1'b1, 0, 1'b0, 1, g);
      chk("rx_after", g, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
